ram128_arbiter: RTL and testbench

//   Shares one 128-deep distributed select-RAM bank (DATA_W parallel RAM128X1S

---
 rtl/ram128_arbiter.sv | 93 +++++++++
 tb/tb_ram128_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram128_arbiter.sv
// ram128_arbiter: two-requester arbiter and clear sequencer in front of a 128-deep RAM128X1S bank
module ram128_arbiter #(
    parameter int                 DATA_W     = 8,
    parameter bit                 RR_EN      = 1'b1,
    parameter bit                 CLR_ON_RST = 1'b1,
    parameter logic [DATA_W-1:0]  CLR_VAL    = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              CLR,
    output logic              BUSY,
    input  logic              A_REQ,
    input  logic              A_WE,
    input  logic [6:0]        A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic              A_GNT,
    output logic              A_RVALID,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WE,
    input  logic [6:0]        B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_GNT,
    output logic              B_RVALID,
    output logic [DATA_W-1:0] B_RDATA,
    output logic              RAM_WE,
    output logic [6:0]        RAM_A,
    output logic [DATA_W-1:0] RAM_D,
    input  logic [DATA_W-1:0] RAM_O
);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d, ram_a_q, ram_a_d;
    logic [DATA_W-1:0] ram_d_q, ram_d_d, a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic              rr_q, rr_d, a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic              idle, a_win, b_win, ram_we_d;

    // arbitration, bank drive and next-state; rr_q=1 means B was served last
    always_comb begin
        idle       = state_q == IDLE;
        a_win      = idle && A_REQ && (!B_REQ || !RR_EN || rr_q);
        b_win      = idle && B_REQ && !a_win;
        ram_we_d   = !idle || (a_win && A_WE) || (b_win && B_WE);
        ram_a_d    = !idle ? cnt_q : a_win ? A_ADDR : b_win ? B_ADDR : ram_a_q;
        ram_d_d    = !idle ? CLR_VAL : a_win ? A_WDATA : b_win ? B_WDATA : ram_d_q;
        state_d    = idle ? (CLR ? CLEAR : IDLE) : (cnt_q == 7'd127 ? IDLE : CLEAR);
        cnt_d      = idle ? 7'd0 : cnt_q + 7'd1;
        rr_d       = a_win ? 1'b0 : b_win ? 1'b1 : rr_q;
        a_rvalid_d = a_win && !A_WE;
        b_rvalid_d = b_win && !B_WE;
        a_rdata_d  = a_rvalid_d ? RAM_O : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? RAM_O : b_rdata_q;
    end

    // outputs forced low while reset is asserted, even though state may already be CLEAR
    always_comb begin
        BUSY     = RST_N && !idle;
        A_GNT    = RST_N && a_win;
        B_GNT    = RST_N && b_win;
        RAM_WE   = RST_N && ram_we_d;
        RAM_A    = RST_N ? ram_a_d : 7'd0;
        RAM_D    = RST_N ? ram_d_d : '0;
        A_RVALID = a_rvalid_q;
        A_RDATA  = a_rdata_q;
        B_RVALID = b_rvalid_q;
        B_RDATA  = b_rdata_q;
    end

    // state, sweep counter, rr pointer, held bank address/data and registered read returns
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= state_t'(CLR_ON_RST);
            cnt_q      <= '0;
            rr_q       <= 1'b1;
            ram_a_q    <= '0;
            ram_d_q    <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end
endmodule

// File: tb/tb_ram128_arbiter.sv
// tb_ram128_arbiter: scoreboard bench for ram128_arbiter with a behavioural LUT-RAM bank
module tb_ram128_arbiter;
    localparam int W = 8;
    logic CLK = 1'b0, RST_N = 1'b0, CLR = 1'b0;
    logic BUSY, A_GNT, A_RVALID, B_GNT, B_RVALID, RAM_WE;
    logic A_REQ = 1'b0, A_WE = 1'b0, B_REQ = 1'b0, B_WE = 1'b0;
    logic [6:0] A_ADDR = '0, B_ADDR = '0, RAM_A;
    logic [W-1:0] A_WDATA = '0, B_WDATA = '0, A_RDATA, B_RDATA, RAM_D, RAM_O;
    logic [W-1:0] mem [128];
    logic F_BUSY, F_A_GNT, F_A_RVALID, F_B_GNT, F_B_RVALID, F_RAM_WE;
    logic F_A_REQ = 1'b0, F_B_REQ = 1'b0;
    logic [6:0] F_RAM_A;
    logic [W-1:0] F_A_RDATA, F_B_RDATA, F_RAM_D;
    logic [W-1:0] f_ram_o = 8'h00;
    int checks = 0, failures = 0;
    logic [W-1:0] exp_a[$], exp_b[$];
    bit exp_g[$];
    logic a_prev = 1'b0, b_prev = 1'b0;

    always #5 CLK = ~CLK;

    ram128_arbiter #(.DATA_W(W), .RR_EN(1'b1), .CLR_ON_RST(1'b1), .CLR_VAL(8'h00)) dut (
        .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .BUSY(BUSY),
        .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
        .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_O(RAM_O)
    );

    ram128_arbiter #(.DATA_W(W), .RR_EN(1'b0), .CLR_ON_RST(1'b0), .CLR_VAL(8'h00)) dut_fp (
        .CLK(CLK), .RST_N(RST_N), .CLR(1'b0), .BUSY(F_BUSY),
        .A_REQ(F_A_REQ), .A_WE(1'b0), .A_ADDR(7'h11), .A_WDATA(8'h00),
        .A_GNT(F_A_GNT), .A_RVALID(F_A_RVALID), .A_RDATA(F_A_RDATA),
        .B_REQ(F_B_REQ), .B_WE(1'b0), .B_ADDR(7'h22), .B_WDATA(8'h00),
        .B_GNT(F_B_GNT), .B_RVALID(F_B_RVALID), .B_RDATA(F_B_RDATA),
        .RAM_WE(F_RAM_WE), .RAM_A(F_RAM_A), .RAM_D(F_RAM_D), .RAM_O(f_ram_o)
    );

    initial for (int i = 0; i < 128; i++) mem[i] = 8'hCC;
    always @(posedge CLK) if (RAM_WE) mem[RAM_A] <= RAM_D;
    assign RAM_O = mem[RAM_A];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // monitor: grant order, one-hot grants, read latency and read data against the queues
    always @(negedge CLK) begin
        if (!RST_N) begin
            a_prev = 1'b0;
            b_prev = 1'b0;
        end else begin
            if (A_GNT || B_GNT) begin
                chk("gnt_excl", {31'd0, A_GNT & B_GNT}, 0);
                if (exp_g.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL gnt_unexpected actual=A%0d_B%0d required=none", A_GNT, B_GNT);
                end else chk("gnt_order", {31'd0, B_GNT}, {31'd0, exp_g.pop_front()});
            end
            chk("a_rvalid_lat", {31'd0, A_RVALID}, {31'd0, a_prev});
            chk("b_rvalid_lat", {31'd0, B_RVALID}, {31'd0, b_prev});
            if (A_RVALID) begin
                if (exp_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_rdata_unexpected actual=%0h required=none", A_RDATA);
                end else chk("a_rdata", {24'd0, A_RDATA}, {24'd0, exp_a.pop_front()});
            end
            if (B_RVALID) begin
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_rdata_unexpected actual=%0h required=none", B_RDATA);
                end else chk("b_rdata", {24'd0, B_RDATA}, {24'd0, exp_b.pop_front()});
            end
            a_prev = A_GNT && !A_WE;
            b_prev = B_GNT && !B_WE;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic req_a(input logic we, input logic [6:0] addr, input logic [W-1:0] wd);
        int n = 0;
        A_REQ = 1'b1; A_WE = we; A_ADDR = addr; A_WDATA = wd;
        @(negedge CLK);
        while (!A_GNT && n < 400) begin n++; @(negedge CLK); end
        if (!A_GNT) begin checks++; failures++; $display("FAIL a_gnt_timeout actual=0 required=1"); end
        tick();
        A_REQ = 1'b0;
    endtask

    task automatic req_b(input logic we, input logic [6:0] addr, input logic [W-1:0] wd);
        int n = 0;
        B_REQ = 1'b1; B_WE = we; B_ADDR = addr; B_WDATA = wd;
        @(negedge CLK);
        while (!B_GNT && n < 400) begin n++; @(negedge CLK); end
        if (!B_GNT) begin checks++; failures++; $display("FAIL b_gnt_timeout actual=0 required=1"); end
        tick();
        B_REQ = 1'b0;
    endtask

    // counts BUSY cycles from the next negedge, checking each sweep step
    task automatic sweep(input string tag, input int stop_at, output int n);
        int bad = 0;
        n = 0;
        @(negedge CLK);
        while (BUSY && n < stop_at) begin
            if (RAM_A !== n[6:0] || RAM_WE !== 1'b1 || RAM_D !== 8'h00 || A_GNT || B_GNT) bad++;
            n++;
            @(negedge CLK);
        end
        chk({tag, "_steps"}, bad, 0);
    endtask

    initial begin
        int n;
        // reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_busy", {31'd0, BUSY}, 0);
        chk("rst_gnt", {30'd0, A_GNT, B_GNT}, 0);
        chk("rst_ram_we", {31'd0, RAM_WE}, 0);
        chk("rst_ram_a", {25'd0, RAM_A}, 0);
        chk("rst_ram_d", {24'd0, RAM_D}, 0);
        chk("rst_rvalid", {30'd0, A_RVALID, B_RVALID}, 0);
        chk("rst_rdata", {16'd0, A_RDATA, B_RDATA}, 0);
        // 1: automatic sweep after reset release
        tick();
        RST_N = 1'b1;
        sweep("clr_rst", 300, n);
        chk("clr_rst_len", n, 128);
        tick();
        exp_g.push_back(0); exp_a.push_back(8'h00);
        req_a(1'b0, 7'h00, 8'h00);
        exp_g.push_back(1); exp_b.push_back(8'h00);
        req_b(1'b0, 7'h7F, 8'h00);
        // fixed priority instance: A every cycle, B starves
        chk("fp_busy", {31'd0, F_BUSY}, 0);
        F_A_REQ = 1'b1; F_B_REQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("fp_a_gnt", {31'd0, F_A_GNT}, 1);
            chk("fp_b_gnt", {31'd0, F_B_GNT}, 0);
            chk("fp_ram_a", {25'd0, F_RAM_A}, 32'h11);
            tick();
        end
        F_A_REQ = 1'b0; F_B_REQ = 1'b0;
        // 2: A writes 0x5A to 0x10 then reads it back
        exp_g.push_back(0);
        req_a(1'b1, 7'h10, 8'h5A);
        exp_g.push_back(0); exp_a.push_back(8'h5A);
        req_a(1'b0, 7'h10, 8'h00);
        repeat (3) tick();
        chk("a_rdata_hold", {24'd0, A_RDATA}, 32'h5A);
        // B write leaves pointer at B, so the contention below starts with A
        exp_g.push_back(1);
        req_b(1'b1, 7'h20, 8'h33);
        // 3: both read-request over four grants: A,B,A,B
        exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(0); exp_g.push_back(1);
        exp_a.push_back(8'h5A); exp_a.push_back(8'h5A);
        exp_b.push_back(8'h33); exp_b.push_back(8'h33);
        fork
            begin req_a(1'b0, 7'h10, 8'h00); req_a(1'b0, 7'h10, 8'h00); end
            begin req_b(1'b0, 7'h20, 8'h00); req_b(1'b0, 7'h20, 8'h00); end
        join
        // 4: A read of 0x7F wins over B write 0xFF, sees old data; repeat read sees new
        exp_g.push_back(0); exp_g.push_back(1); exp_a.push_back(8'h00);
        fork
            req_a(1'b0, 7'h7F, 8'h00);
            req_b(1'b1, 7'h7F, 8'hFF);
        join
        exp_g.push_back(0); exp_a.push_back(8'hFF);
        req_a(1'b0, 7'h7F, 8'h00);
        // read in the cycle right after a write to the same address
        exp_g.push_back(1); exp_g.push_back(0); exp_a.push_back(8'h44);
        req_b(1'b1, 7'h30, 8'h44);
        req_a(1'b0, 7'h30, 8'h00);
        // 5: CLR with A_REQ, mid-sweep CLR ignored, pending B read granted as BUSY drops
        exp_g.push_back(0);
        A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 7'h05; A_WDATA = 8'h77; CLR = 1'b1;
        @(negedge CLK);
        chk("clr_cycle_a_gnt", {31'd0, A_GNT}, 1);
        chk("clr_cycle_busy", {31'd0, BUSY}, 0);
        tick();
        A_REQ = 1'b0; CLR = 1'b0;
        exp_g.push_back(1); exp_b.push_back(8'h00);
        B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 7'h05;
        fork
            begin repeat (60) @(posedge CLK); #1 CLR = 1'b1; @(posedge CLK); #1 CLR = 1'b0; end
        join_none
        sweep("clr_cmd", 300, n);
        chk("clr_cmd_len", n, 128);
        chk("clr_end_b_gnt", {31'd0, B_GNT}, 1);
        tick();
        B_REQ = 1'b0;
        exp_g.push_back(0);
        req_a(1'b1, 7'h60, 8'h99);
        // 6: reset at sweep word 40, sweep restarts from 0
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        sweep("clr_abort", 40, n);
        chk("clr_abort_at", n, 40);
        #2 RST_N = 1'b0;
        #1;
        chk("abort_busy", {31'd0, BUSY}, 0);
        chk("abort_ram_we", {31'd0, RAM_WE}, 0);
        chk("abort_ram_a", {25'd0, RAM_A}, 0);
        chk("abort_rdata", {24'd0, A_RDATA}, 0);
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        sweep("clr_restart", 300, n);
        chk("clr_restart_len", n, 128);
        tick();
        // pointer back to "last served B" after reset; 0x60 was cleared
        exp_g.push_back(0); exp_g.push_back(1);
        exp_a.push_back(8'h00); exp_b.push_back(8'h00);
        fork
            req_a(1'b0, 7'h60, 8'h00);
            req_b(1'b0, 7'h00, 8'h00);
        join
        repeat (3) tick();
        chk("sb_empty", exp_a.size() + exp_b.size() + exp_g.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
